// File: rtl/prog_mod_counter.sv
// prog_mod_counter: programmable modulo up/down counter with terminal-count pulse and divided clock
//   i_clk, i_areset_n        clock, asynchronous active-low reset
//   i_clear, i_load, i_en    synchronous clear > load > enable
//   i_load_val, i_max        load value, terminal value (modulus i_max+1)
//   i_up, i_mode             direction, clk_out mode (0 pulse, 1 toggle)
//   o_count, o_tc, o_clk_out registered count, wrap pulse, divided clock
module prog_mod_counter #(
  parameter int WIDTH   = 8,
  parameter int RST_DIR = 1
) (
  input  logic             i_clk,
  input  logic             i_areset_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_clk_out
);
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_clk_out;
  logic             w_hit;
  logic             w_wrap;
  logic [WIDTH-1:0] w_step;
  if (WIDTH < 2 || RST_DIR < 0 || RST_DIR > 1) begin : g_bad_param
    $error("prog_mod_counter: WIDTH must be >= 2 and RST_DIR 0 or 1");
  end
  // out-of-range counts (after a load or a shrinking max) fall into the wrap branch
  always_comb begin
    w_hit  = i_up ? (r_count >= i_max) : (r_count == '0 || r_count > i_max);
    w_wrap = ~i_clear & ~i_load & i_en & w_hit;
    w_step = i_up ? (w_hit ? '0 : r_count + 1'b1) : (w_hit ? i_max : r_count - 1'b1);
  end
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_count   <= '0;
      r_tc      <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      r_count   <= i_clear ? '0 : i_load ? i_load_val : i_en ? w_step : r_count;
      r_tc      <= w_wrap;
      r_clk_out <= ~i_clear & (i_mode ? r_clk_out ^ w_wrap : w_wrap);
    end
  end
  assign o_count   = r_count;
  assign o_tc      = r_tc;
  assign o_clk_out = r_clk_out;
endmodule

// File: tb/tb_prog_mod_counter.sv
// tb_prog_mod_counter: directed plus randomized checks of prog_mod_counter against a modular-arithmetic model
module tb_prog_mod_counter;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         mode = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] max = '0;
  logic [W-1:0] count;
  logic         tc;
  logic         co;
  int           passed = 0;
  int           total = 0;
  int           m_cnt = 0;
  int           m_tc = 0;
  int           m_co = 0;
  prog_mod_counter #(.WIDTH(W), .RST_DIR(1)) dut (
    .i_clk(clk), .i_areset_n(rst_n), .i_clear(clear), .i_load(load),
    .i_load_val(load_val), .i_en(en), .i_up(up), .i_mode(mode), .i_max(max),
    .o_count(count), .o_tc(tc), .o_clk_out(co)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".count"}, {24'd0, count}, m_cnt);
    chk({tag, ".tc"}, {31'd0, tc}, m_tc);
    chk({tag, ".clk_out"}, {31'd0, co}, m_co);
  endtask
  task automatic model_reset();
    m_cnt = 0;
    m_tc  = 0;
    m_co  = 0;
  endtask
  task automatic model_edge();
    int mx = int'(max);
    int m  = mx + 1;
    int w  = 0;
    if (clear) begin
      model_reset();
    end else if (load) begin
      m_cnt = int'(load_val);
      m_tc  = 0;
      m_co  = mode ? m_co : 0;
    end else begin
      if (en && up) begin
        w     = (m_cnt >= mx) ? 1 : 0;
        m_cnt = (m_cnt > mx) ? 0 : (m_cnt + 1) % m;
      end else if (en) begin
        w     = (m_cnt == 0 || m_cnt > mx) ? 1 : 0;
        m_cnt = (m_cnt > mx) ? mx : (m_cnt + mx) % m;
      end
      m_tc = w;
      m_co = mode ? (m_co ^ w) : w;
    end
  endtask
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    #3;
    check_all("reset_hold");
    #10 rst_n = 1'b1;
    max = 8'd4; up = 1'b1; mode = 1'b0; en = 1'b1;
    repeat (12) tick("up_pulse");
    mode = 1'b1;
    repeat (20) tick("toggle_m4");
    max = 8'd0;
    repeat (6) begin
      tick("toggle_m0");
      chk("m0_tc_high", {31'd0, tc}, 32'd1);
    end
    up = 1'b0; max = 8'd9; mode = 1'b0; load = 1'b1; load_val = 8'd2;
    tick("down_load2");
    load = 1'b0;
    repeat (6) tick("down_run");
    load = 1'b1; load_val = 8'd200;
    tick("load200");
    chk("load200_count", {24'd0, count}, 32'd200);
    load = 1'b0;
    tick("load200_step");
    chk("over_max_down_count", {24'd0, count}, 32'd9);
    chk("over_max_down_tc", {31'd0, tc}, 32'd1);
    mode = 1'b1;
    repeat (3) tick("down_toggle");
    clear = 1'b1; load = 1'b1; en = 1'b1;
    tick("prio_clear");
    chk("prio_clear_count", {24'd0, count}, 32'd0);
    chk("prio_clear_co", {31'd0, co}, 32'd0);
    clear = 1'b0; load_val = 8'd7;
    tick("prio_load");
    chk("prio_load_count", {24'd0, count}, 32'd7);
    load = 1'b0; en = 1'b0;
    repeat (3) begin
      tick("hold");
      chk("hold_count", {24'd0, count}, 32'd7);
    end
    up = 1'b1; en = 1'b1; max = 8'd20; load = 1'b1; load_val = 8'd8;
    tick("shrink_load");
    load = 1'b0; max = 8'd3;
    tick("shrink");
    chk("shrink_count", {24'd0, count}, 32'd0);
    chk("shrink_tc", {31'd0, tc}, 32'd1);
    max = 8'd9;
    repeat (3) tick("pre_areset");
    async_reset("mid_areset");
    tick("post_areset");
    chk("post_areset_count", {24'd0, count}, 32'd1);
    repeat (400) begin
      clear    = ($urandom_range(0, 31) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up = ~up;
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) max = W'($urandom_range(0, 15));
      load_val = W'($urandom_range(0, 255));
      tick("rand");
      if ($urandom_range(0, 63) == 0) async_reset("rand_areset");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
